// File: rtl/dds_pkg.sv
// dds_pkg: shared waveform codes and pipeline constants
// for the dds_wavegen signal generator.
package dds_pkg;

  typedef enum logic [1:0] {
    WAVE_SINE   = 2'd0,
    WAVE_SQUARE = 2'd1,
    WAVE_TRI    = 2'd2,
    WAVE_SAW    = 2'd3
  } wave_e;

  localparam int DDS_LAT = 4;

endpackage

// File: rtl/dds_quarter_rom.sv
// dds_quarter_rom: quarter-wave sine table, synchronous read,
// one cycle latency, no reset on the data register.
module dds_quarter_rom #(
  parameter int    LUT_AW   = 8,
  parameter int    DATA_W   = 13,
  parameter string LUT_FILE = "quarter_sine_lut.txt"
) (
  input  logic              clk,
  input  logic [LUT_AW-1:0] addr_i,
  output logic [DATA_W-1:0] data_o
);

  localparam int     DEPTH  = 1 << LUT_AW;
  localparam longint PI_Q30 = 64'sd3373259426;

  // round((2^DATA_W-1)*sin((i+0.5)*pi/2^(LUT_AW+1))), Q30 Taylor series
  function automatic logic [DATA_W-1:0] sin_entry(input int idx);
    longint x;
    longint x2;
    longint term;
    longint sum;
    longint mx;
    x    = (longint'(2 * idx + 1) * PI_Q30) >>> (LUT_AW + 2);
    x2   = (x * x) >>> 30;
    term = x;
    sum  = x;
    for (int k = 1; k < 8; k++) begin
      term = -((term * x2) >>> 30) / longint'((2 * k) * (2 * k + 1));
      sum  = sum + term;
    end
    mx = (longint'(1) << DATA_W) - 1;
    return DATA_W'((mx * sum + (longint'(1) << 29)) >>> 30);
  endfunction

  logic [DATA_W-1:0] rom [DEPTH];
  logic [DATA_W-1:0] data_q;

  for (genvar g = 0; g < DEPTH; g++) begin : g_rom
    localparam logic [DATA_W-1:0] V = sin_entry(g);
    assign rom[g] = V;
  end

  always_ff @(posedge clk) begin
    data_q <= rom[addr_i];
  end

  assign data_o = data_q;

endmodule

// File: rtl/dds_wavegen.sv
// dds_wavegen: four-stage DDS (sine/square/triangle/saw) driving
// an offset-binary DAC sample with valid and cycle-wrap flags.
module dds_wavegen
  import dds_pkg::*;
#(
  parameter int    ACC_W    = 32,
  parameter int    LUT_AW   = 8,
  parameter int    OUT_W    = 14,
  parameter int    AMP_W    = 16,
  parameter string LUT_FILE = "quarter_sine_lut.txt",
  localparam int   PHASE_W  = LUT_AW + 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [ACC_W-1:0]   freq_word,
  input  logic               freq_load,
  input  logic [PHASE_W-1:0] phase_offset,
  input  logic               phase_sync,
  input  logic [1:0]         wave_sel,
  input  logic [AMP_W-1:0]   amplitude,
  output logic [OUT_W-1:0]   dout,
  output logic               dout_valid,
  output logic               wrap
);

  localparam int MAG_W = OUT_W - 1;
  localparam int TSH   = OUT_W - PHASE_W + 1;
  localparam int SSH   = OUT_W - PHASE_W;
  localparam logic [MAG_W-1:0]   MX   = '1;
  localparam logic [OUT_W-1:0]   MID  = OUT_W'(1) << MAG_W;
  localparam logic [PHASE_W-1:0] HALF = PHASE_W'(1) << (PHASE_W - 1);

  function automatic logic [MAG_W-1:0] sat(input logic [OUT_W-1:0] v);
    return v[OUT_W-1] ? MX : v[MAG_W-1:0];
  endfunction

  logic [ACC_W-1:0]   acc_q, acc_d, freq_q;
  logic               carry_q, carry_d;
  logic [PHASE_W-1:0] p1_q, p2_q;
  wave_e              w1_q, w2_q;
  logic               c1_q, c2_q, c3_q, wrap_q;
  logic [DDS_LAT-1:0] vld_q;
  logic [LUT_AW-1:0]  rom_addr;
  logic [MAG_W-1:0]   rom_data;
  logic [PHASE_W-1:0] tri_x, saw_x;
  logic [MAG_W-1:0]   mag_d, mag_q;
  logic               neg_d, neg_q;
  logic [MAG_W+AMP_W-1:0] prod;
  logic [MAG_W-1:0]   smag;
  logic [OUT_W-1:0]   dout_d, dout_q;

  always_comb begin
    acc_d   = acc_q;
    carry_d = 1'b0;
    if (phase_sync) begin
      acc_d = '0;
    end else if (en) begin
      {carry_d, acc_d} = {1'b0, acc_q} + {1'b0, freq_q};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q   <= '0;
      freq_q  <= '0;
      carry_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      carry_q <= carry_d;
      if (freq_load) freq_q <= freq_word;
    end
  end

  // odd quadrants read the table backwards
  assign rom_addr = p1_q[PHASE_W-2] ? ~p1_q[LUT_AW-1:0]
                                    : p1_q[LUT_AW-1:0];

  dds_quarter_rom #(
    .LUT_AW   (LUT_AW),
    .DATA_W   (MAG_W),
    .LUT_FILE (LUT_FILE)
  ) u_rom (
    .clk    (clk),
    .addr_i (rom_addr),
    .data_o (rom_data)
  );

  always_comb begin
    tri_x = {1'b0, p2_q[PHASE_W-2:0]};
    if (p2_q[PHASE_W-2]) tri_x = HALF - tri_x;
    saw_x = p2_q[PHASE_W-1] ? p2_q - HALF : HALF - p2_q;
    mag_d = '0;
    neg_d = p2_q[PHASE_W-1];
    unique case (w2_q)
      WAVE_SINE:   mag_d = rom_data;
      WAVE_SQUARE: mag_d = MX;
      WAVE_TRI:    mag_d = sat(OUT_W'(tri_x) << TSH);
      WAVE_SAW: begin
        mag_d = sat(OUT_W'(saw_x) << SSH);
        neg_d = ~p2_q[PHASE_W-1];
      end
    endcase
    // ROM data is unreset; keep flushed slots at midscale
    if (!vld_q[1]) begin
      mag_d = '0;
      neg_d = 1'b0;
    end
  end

  assign prod   = {{AMP_W{1'b0}}, mag_q} * {{MAG_W{1'b0}}, amplitude};
  assign smag   = MAG_W'(prod >> AMP_W);
  assign dout_d = neg_q ? MID - {1'b0, smag} : MID + {1'b0, smag};

  always_ff @(posedge clk) begin
    if (rst) begin
      p1_q   <= '0;
      w1_q   <= WAVE_SINE;
      c1_q   <= 1'b0;
      p2_q   <= '0;
      w2_q   <= WAVE_SINE;
      c2_q   <= 1'b0;
      mag_q  <= '0;
      neg_q  <= 1'b0;
      c3_q   <= 1'b0;
      dout_q <= MID;
      wrap_q <= 1'b0;
      vld_q  <= '0;
    end else begin
      p1_q   <= acc_q[ACC_W-1 -: PHASE_W] + phase_offset;
      w1_q   <= wave_e'(wave_sel);
      c1_q   <= carry_q;
      p2_q   <= p1_q;
      w2_q   <= w1_q;
      c2_q   <= c1_q;
      mag_q  <= mag_d;
      neg_q  <= neg_d;
      c3_q   <= c2_q;
      dout_q <= dout_d;
      wrap_q <= c3_q;
      vld_q  <= {vld_q[DDS_LAT-2:0], 1'b1};
    end
  end

  assign dout       = dout_q;
  assign dout_valid = vld_q[DDS_LAT-1];
  assign wrap       = wrap_q;

endmodule

// File: tb/tb_dds_wavegen.sv
// tb_dds_wavegen: scoreboard bench for dds_wavegen, golden
// model of the accumulator and per-waveform sample math.
module tb_dds_wavegen;

  localparam int M = 8192;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [31:0] freq_word;
  logic        freq_load;
  logic [9:0]  phase_offset;
  logic        phase_sync;
  logic [1:0]  wave_sel;
  logic [15:0] amplitude;
  logic [13:0] dout;
  logic        dout_valid;
  logic        wrap;

  always #4 clk = ~clk;

  dds_wavegen dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .freq_word    (freq_word),
    .freq_load    (freq_load),
    .phase_offset (phase_offset),
    .phase_sync   (phase_sync),
    .wave_sel     (wave_sel),
    .amplitude    (amplitude),
    .dout         (dout),
    .dout_valid   (dout_valid),
    .wrap         (wrap)
  );

  typedef struct {
    bit chk;
    int dout;
    bit valid;
    bit wrap;
  } exp_t;

  exp_t        sbq[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] acc_m;
  logic [31:0] freq_m;
  int          rom_g[256];

  task automatic check_eq(input string tag, input longint got,
                          input longint exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int gold(input logic [31:0] acc, input int off,
                              input int ws, input int amp);
    int p, mag, neg, x, addr, smag;
    p = (int'(acc[31:22]) + off) & 1023;
    neg = (p >> 9) & 1;
    addr = (p & 256) != 0 ? 255 - (p & 255) : (p & 255);
    case (ws)
      0: mag = rom_g[addr];
      1: mag = 8191;
      2: begin
        x = p & 511;
        if ((p & 256) != 0) x = 512 - x;
        mag = (x * 32 > 8191) ? 8191 : x * 32;
      end
      default: begin
        if (p >= 512) begin
          neg = 0;
          x = p - 512;
        end else begin
          neg = 1;
          x = 512 - p;
        end
        mag = (x * 16 > 8191) ? 8191 : x * 16;
      end
    endcase
    smag = (mag * amp) >>> 16;
    return neg != 0 ? M - smag : M + smag;
  endfunction

  function automatic void flush_chk();
    foreach (sbq[i]) sbq[i].chk = 1'b0;
  endfunction

  task automatic tick();
    exp_t        e;
    bit          c;
    logic [32:0] s;
    if (rst) begin
      acc_m  = '0;
      freq_m = '0;
      sbq.delete();
      repeat (3) sbq.push_back(exp_t'{chk: 1'b1, dout: M,
                                      valid: 1'b0, wrap: 1'b0});
      e = exp_t'{chk: 1'b1, valid: 1'b1, wrap: 1'b0,
                 dout: gold(acc_m, phase_offset, wave_sel, amplitude)};
      sbq.push_back(e);
    end else begin
      c = 1'b0;
      if (phase_sync) begin
        acc_m = '0;
      end else if (en) begin
        s = {1'b0, acc_m} + {1'b0, freq_m};
        c = s[32];
        acc_m = s[31:0];
      end
      if (freq_load) freq_m = freq_word;
      e = exp_t'{chk: 1'b1, valid: 1'b1, wrap: c,
                 dout: gold(acc_m, phase_offset, wave_sel, amplitude)};
      sbq.push_back(e);
    end
    @(posedge clk);
    #1;
    if (rst) begin
      check_eq("rst_dout", dout, M);
      check_eq("rst_valid", dout_valid, 0);
      check_eq("rst_wrap", wrap, 0);
    end else if (sbq.size() > 4) begin
      e = sbq.pop_front();
      check_eq("valid", dout_valid, e.valid);
      check_eq("wrap", wrap, e.wrap);
      if (e.chk) check_eq("dout", dout, e.dout);
    end
  endtask

  int hi, wr, mx, mn, dec, prev, peak;
  int smp[256];

  initial begin
    for (int i = 0; i < 256; i++)
      rom_g[i] = $rtoi($floor(8191.0 *
                 $sin((i + 0.5) * 3.141592653589793 / 512.0) + 0.5));
    peak = M + ((rom_g[255] * 65535) >>> 16);

    rst = 1'b1; en = 1'b1; freq_word = '0; freq_load = 1'b0;
    phase_offset = '0; phase_sync = 1'b0; wave_sel = 2'd1;
    amplitude = 16'hFFFF;
    repeat (3) tick();
    rst = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      check_eq("valid_rise", dout_valid, k >= 4);
    end

    // square, full scale, 256-cycle period
    freq_word = 32'h0100_0000; freq_load = 1'b1;
    tick();
    freq_load = 1'b0;
    repeat (8) tick();
    hi = 0; wr = 0;
    repeat (512) begin
      tick();
      wr += int'(wrap);
      hi += int'(dout == 14'd16382);
    end
    check_eq("sq_wraps", wr, 2);
    check_eq("sq_high", hi, 256);

    // sine: peak and half-cycle symmetry
    wave_sel = 2'd0; flush_chk();
    repeat (8) tick();
    mx = 0;
    for (int k = 0; k < 256; k++) begin
      tick();
      smp[k] = int'(dout);
      if (smp[k] > mx) mx = smp[k];
    end
    check_eq("sine_peak", mx, peak);
    check_eq("sym0", smp[0] + smp[128], 16384);
    check_eq("sym37", smp[37] + smp[165], 16384);
    check_eq("sym100", smp[100] + smp[228], 16384);

    // zero and half amplitude
    amplitude = '0; flush_chk();
    repeat (5) tick();
    check_eq("amp0_sine", dout, M);
    wave_sel = 2'd2; flush_chk();
    repeat (5) tick();
    check_eq("amp0_tri", dout, M);
    wave_sel = 2'd1; amplitude = 16'h8000; flush_chk();
    repeat (5) tick();
    repeat (20) begin
      tick();
      check_eq("sq_half", (dout == 14'd12287 || dout == 14'd4097), 1);
    end

    // phase sync with new frequency, quarter-cycle offset
    amplitude = 16'hFFFF; wave_sel = 2'd0; phase_offset = 10'd256;
    flush_chk();
    repeat (30) tick();
    freq_word = 32'h0080_0000; freq_load = 1'b1; phase_sync = 1'b1;
    tick();
    freq_load = 1'b0; phase_sync = 1'b0;
    repeat (4) tick();
    check_eq("sync_peak", dout, peak);
    repeat (300) tick();

    // sawtooth ramp, 1024-cycle period
    phase_offset = '0; wave_sel = 2'd3; flush_chk();
    freq_word = 32'h0040_0000; freq_load = 1'b1;
    tick();
    freq_load = 1'b0;
    repeat (8) tick();
    prev = int'(dout); dec = 0;
    repeat (1024) begin
      tick();
      dec += int'(int'(dout) < prev);
      prev = int'(dout);
    end
    check_eq("saw_drops", dec, 1);

    // triangle extremes
    wave_sel = 2'd2; flush_chk();
    repeat (8) tick();
    mx = 0; mn = 1 << 14;
    repeat (1024) begin
      tick();
      if (int'(dout) > mx) mx = int'(dout);
      if (int'(dout) < mn) mn = int'(dout);
    end
    check_eq("tri_max", mx, 16382);
    check_eq("tri_min", mn, 2);

    // accumulator hold
    en = 1'b0;
    repeat (5) tick();
    repeat (10) begin
      tick();
      check_eq("frozen", dout, gold(acc_m, 0, 2, 16'hFFFF));
      check_eq("frozen_wrap", wrap, 0);
    end
    en = 1'b1;
    repeat (50) tick();

    // mid-operation reset
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    repeat (20) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
